// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - three-way SRAM port arbiter with read-tag return and starve flags
module sram_port_arbiter #(
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 2,
   parameter int STARVE_LIMIT = 255
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              VGA_req,
   input  logic [ADDR_W-1:0] VGA_address,
   output logic              VGA_rvalid,
   input  logic              DEC_req,
   input  logic              DEC_we,
   input  logic [ADDR_W-1:0] DEC_address,
   input  logic [DATA_W-1:0] DEC_write_data,
   output logic              DEC_gnt,
   output logic              DEC_rvalid,
   input  logic              UART_req,
   input  logic [ADDR_W-1:0] UART_address,
   input  logic [DATA_W-1:0] UART_write_data,
   output logic              UART_gnt,
   output logic [ADDR_W-1:0] SRAM_address,
   output logic [DATA_W-1:0] SRAM_write_data,
   output logic              SRAM_we_n,
   input  logic [DATA_W-1:0] SRAM_read_data,
   output logic [DATA_W-1:0] read_data,
   output logic [1:0]        owner,
   output logic [1:0]        starve_flag
);

   localparam logic [1:0] OWN_IDLE = 2'd0;
   localparam logic [1:0] OWN_VGA  = 2'd1;
   localparam logic [1:0] OWN_DEC  = 2'd2;
   localparam logic [1:0] OWN_UART = 2'd3;
   localparam logic [7:0] LIMIT_C  = 8'(STARVE_LIMIT);

   typedef enum logic {RR_DEC = 1'b0, RR_UART = 1'b1} rr_e;

   rr_e               rr_q, rr_d;
   logic              vga_win, dec_win, uart_win;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic              we_n_q, we_n_d;
   logic [1:0]        owner_q, owner_d;
   // Tag bit 1 marks a VGA read, bit 0 a decoder read.
   logic [1:0]        tag_q [READ_LATENCY];
   logic [1:0]        tag_d [READ_LATENCY];
   logic [7:0]        dec_cnt_q, dec_cnt_d, uart_cnt_q, uart_cnt_d;
   logic [1:0]        starve_q, starve_d;

   // Winner selection: VGA preempts, DEC/UART alternate only when both ask.
   always_comb begin
      vga_win  = VGA_req;
      dec_win  = 1'b0;
      uart_win = 1'b0;
      rr_d     = rr_q;
      if (!VGA_req) begin
         if (DEC_req && UART_req) begin
            if (rr_q == RR_DEC) begin
               dec_win = 1'b1;
               rr_d    = RR_UART;
            end else begin
               uart_win = 1'b1;
               rr_d     = RR_DEC;
            end
         end else begin
            dec_win  = DEC_req;
            uart_win = UART_req;
         end
      end
   end

   // Next pin state: winner's request, or idle with address/data held.
   always_comb begin
      addr_d  = addr_q;
      wd_d    = wd_q;
      we_n_d  = 1'b1;
      owner_d = OWN_IDLE;
      if (vga_win) begin
         addr_d  = VGA_address;
         owner_d = OWN_VGA;
      end else if (dec_win) begin
         addr_d  = DEC_address;
         wd_d    = DEC_write_data;
         we_n_d  = ~DEC_we;
         owner_d = OWN_DEC;
      end else if (uart_win) begin
         addr_d  = UART_address;
         wd_d    = UART_write_data;
         we_n_d  = 1'b0;
         owner_d = OWN_UART;
      end
   end

   // Read-tag shift line aligned with the SRAM read latency.
   always_comb begin
      tag_d[0] = {vga_win, dec_win & ~DEC_we};
      for (int i = 1; i < READ_LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // Saturating starve counters and sticky flags.
   always_comb begin
      dec_cnt_d  = dec_cnt_q;
      uart_cnt_d = uart_cnt_q;
      if (dec_win) begin
         dec_cnt_d = 8'd0;
      end else if (DEC_req && dec_cnt_q != 8'hFF) begin
         dec_cnt_d = dec_cnt_q + 8'd1;
      end
      if (uart_win) begin
         uart_cnt_d = 8'd0;
      end else if (UART_req && uart_cnt_q != 8'hFF) begin
         uart_cnt_d = uart_cnt_q + 8'd1;
      end
      starve_d[0] = starve_q[0] | (dec_cnt_d == LIMIT_C);
      starve_d[1] = starve_q[1] | (uart_cnt_d == LIMIT_C);
   end

   // State registers; reset forces the pins idle immediately.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rr_q       <= RR_DEC;
         addr_q     <= '0;
         wd_q       <= '0;
         we_n_q     <= 1'b1;
         owner_q    <= OWN_IDLE;
         dec_cnt_q  <= 8'd0;
         uart_cnt_q <= 8'd0;
         starve_q   <= 2'b00;
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_q[i] <= 2'b00;
         end
      end else begin
         rr_q       <= rr_d;
         addr_q     <= addr_d;
         wd_q       <= wd_d;
         we_n_q     <= we_n_d;
         owner_q    <= owner_d;
         dec_cnt_q  <= dec_cnt_d;
         uart_cnt_q <= uart_cnt_d;
         starve_q   <= starve_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign DEC_gnt         = dec_win;
   assign UART_gnt        = uart_win;
   assign SRAM_address    = addr_q;
   assign SRAM_write_data = wd_q;
   assign SRAM_we_n       = we_n_q;
   assign owner           = owner_q;
   assign starve_flag     = starve_q;
   assign read_data       = SRAM_read_data;
   assign VGA_rvalid      = tag_q[READ_LATENCY-1][1];
   assign DEC_rvalid      = tag_q[READ_LATENCY-1][0];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - table-driven and scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        VGA_req = 1'b0;
   logic [17:0] VGA_address = '0;
   logic        VGA_rvalid;
   logic        DEC_req = 1'b0;
   logic        DEC_we = 1'b0;
   logic [17:0] DEC_address = '0;
   logic [15:0] DEC_write_data = '0;
   logic        DEC_gnt;
   logic        DEC_rvalid;
   logic        UART_req = 1'b0;
   logic [17:0] UART_address = '0;
   logic [15:0] UART_write_data = '0;
   logic        UART_gnt;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic [15:0] SRAM_read_data;
   logic [15:0] read_data;
   logic [1:0]  owner;
   logic [1:0]  starve_flag;

   sram_port_arbiter dut (
      .Clock(Clock), .Reset(Reset),
      .VGA_req(VGA_req), .VGA_address(VGA_address), .VGA_rvalid(VGA_rvalid),
      .DEC_req(DEC_req), .DEC_we(DEC_we), .DEC_address(DEC_address),
      .DEC_write_data(DEC_write_data), .DEC_gnt(DEC_gnt), .DEC_rvalid(DEC_rvalid),
      .UART_req(UART_req), .UART_address(UART_address), .UART_write_data(UART_write_data),
      .UART_gnt(UART_gnt), .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
      .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data), .read_data(read_data),
      .owner(owner), .starve_flag(starve_flag)
   );

   always #10 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      logic        vr; logic [17:0] va;
      logic        dr; logic dw; logic [17:0] da; logic [15:0] dd;
      logic        ur; logic [17:0] ua; logic [15:0] ud;
      logic        edg; logic eug;
   } req_t;

   typedef struct {
      logic vr; logic dr; logic dw; logic ur; logic edg; logic eug;
   } vec_t;

   typedef struct {
      logic [1:0]  src;
      logic [15:0] data;
      int          cyc;
   } rd_t;

   rd_t         sbq[$];
   logic [17:0] exp_addr = '0;
   logic [15:0] exp_wd = '0;

   function automatic logic [15:0] sram_val(input logic [17:0] a);
      if (a == 18'h00100) return 16'hBEEF;
      return a[15:0] ^ 16'hA5A5;
   endfunction

   logic [15:0] sram_rd_q = '0;
   always @(posedge Clock) sram_rd_q <= sram_val(SRAM_address);
   assign SRAM_read_data = sram_rd_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Read-return monitor: pops the scoreboard on every rvalid.
   always @(negedge Clock) begin
      if (!Reset && (VGA_rvalid || DEC_rvalid)) begin
         checks++;
         if (VGA_rvalid && DEC_rvalid) begin
            errors++;
            $display("FAIL rvalid_onehot actual=both required=one");
         end else if (sbq.size() == 0) begin
            errors++;
            $display("FAIL rvalid_unexpected actual=vga%0b_dec%0b required=none cyc=%0d",
                     VGA_rvalid, DEC_rvalid, cyc);
         end else begin
            rd_t e;
            e = sbq.pop_front();
            if ({VGA_rvalid, DEC_rvalid} !== e.src || read_data !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL rvalid_return actual=src%0b_data%0h_cyc%0d required=src%0b_data%0h_cyc%0d",
                        {VGA_rvalid, DEC_rvalid}, read_data, cyc, e.src, e.data, e.cyc);
            end
         end
      end
   end

   task automatic do_cycle(input req_t r, input string name);
      logic [1:0] own;
      logic       wen;
      rd_t        e;
      VGA_req = r.vr; VGA_address = r.va;
      DEC_req = r.dr; DEC_we = r.dw; DEC_address = r.da; DEC_write_data = r.dd;
      UART_req = r.ur; UART_address = r.ua; UART_write_data = r.ud;
      @(negedge Clock);
      chk({name, "_dec_gnt"}, 32'(DEC_gnt), 32'(r.edg));
      chk({name, "_uart_gnt"}, 32'(UART_gnt), 32'(r.eug));
      own = 2'd0; wen = 1'b1;
      if (r.vr) begin
         own = 2'd1; exp_addr = r.va;
         e.src = 2'b10; e.data = sram_val(r.va); e.cyc = cyc + 2; sbq.push_back(e);
      end else if (r.edg) begin
         own = 2'd2; exp_addr = r.da; exp_wd = r.dd; wen = ~r.dw;
         if (!r.dw) begin
            e.src = 2'b01; e.data = sram_val(r.da); e.cyc = cyc + 2; sbq.push_back(e);
         end
      end else if (r.eug) begin
         own = 2'd3; exp_addr = r.ua; exp_wd = r.ud; wen = 1'b0;
      end
      @(posedge Clock); #1;
      chk({name, "_owner"}, 32'(owner), 32'(own));
      chk({name, "_we_n"}, 32'(SRAM_we_n), 32'(wen));
      chk({name, "_addr"}, 32'(SRAM_address), 32'(exp_addr));
      chk({name, "_wdata"}, 32'(SRAM_write_data), 32'(exp_wd));
   endtask

   task automatic idle(input int n);
      req_t r;
      r = '{default: '0};
      for (int i = 0; i < n; i++) do_cycle(r, "idle");
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      VGA_req = 1'b0; DEC_req = 1'b0; UART_req = 1'b0;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      sbq.delete();
      exp_addr = '0; exp_wd = '0;
      chk("rst_addr", 32'(SRAM_address), 32'h0);
      chk("rst_wdata", 32'(SRAM_write_data), 32'h0);
      chk("rst_we_n", 32'(SRAM_we_n), 32'h1);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_rvalid", 32'({VGA_rvalid, DEC_rvalid}), 32'h0);
      chk("rst_starve", 32'(starve_flag), 32'h0);
      Reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[12];
      req_t r;

      tbl[0]  = '{1, 1, 0, 1, 0, 0};
      tbl[1]  = '{0, 1, 0, 1, 1, 0};
      tbl[2]  = '{0, 1, 1, 1, 0, 1};
      tbl[3]  = '{0, 0, 0, 1, 0, 1};
      tbl[4]  = '{0, 1, 0, 0, 1, 0};
      tbl[5]  = '{0, 1, 1, 1, 1, 0};
      tbl[6]  = '{0, 0, 0, 0, 0, 0};
      tbl[7]  = '{1, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 0, 1, 0, 1};
      tbl[9]  = '{0, 1, 0, 0, 1, 0};
      tbl[10] = '{1, 0, 0, 1, 0, 0};
      tbl[11] = '{0, 1, 0, 1, 1, 0};

      apply_reset();

      // Reset while a decoder read is in flight.
      r = '{default: '0};
      r.dr = 1; r.da = 18'h00100; r.edg = 1;
      do_cycle(r, "t1_grant");
      DEC_req = 1'b0;
      #4 Reset = 1'b1;
      #1;
      chk("t1_async_we_n", 32'(SRAM_we_n), 32'h1);
      chk("t1_async_owner", 32'(owner), 32'h0);
      sbq.delete();
      exp_addr = '0; exp_wd = '0;
      @(posedge Clock); #1;
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         chk("t1_no_rvalid", 32'(DEC_rvalid), 32'h0);
      end
      @(posedge Clock); #1;

      // Lone decoder read with explicit latency check.
      r = '{default: '0};
      r.dr = 1; r.da = 18'h00100; r.edg = 1;
      do_cycle(r, "t2_grant");
      DEC_req = 1'b0;
      @(negedge Clock);
      chk("t2_rvalid_c1", 32'(DEC_rvalid), 32'h0);
      @(negedge Clock);
      chk("t2_rvalid_c2", 32'(DEC_rvalid), 32'h1);
      chk("t2_data_c2", 32'(read_data), 32'hBEEF);
      @(negedge Clock);
      chk("t2_rvalid_c3", 32'(DEC_rvalid), 32'h0);
      @(posedge Clock); #1;

      // All three requesting: VGA always wins.
      for (int i = 0; i < 3; i++) begin
         r = '{default: '0};
         r.vr = 1; r.va = 18'(i);
         r.dr = 1; r.da = 18'h00200;
         r.ur = 1; r.ua = 18'h00300; r.ud = 16'h1234;
         do_cycle(r, "t3_all");
      end
      idle(3);

      // Contested DEC/UART writes alternate.
      for (int i = 0; i < 4; i++) begin
         r = '{default: '0};
         r.dr = 1; r.dw = 1; r.da = 18'h00400 + 18'(i); r.dd = 16'hD000 + 16'(i);
         r.ur = 1; r.ua = 18'h00500 + 18'(i); r.ud = 16'hC000 + 16'(i);
         r.edg = (i % 2 == 0); r.eug = (i % 2 == 1);
         do_cycle(r, "t4_rr");
      end
      idle(1);

      // Mixed back-to-back reads.
      r = '{default: '0}; r.vr = 1; r.va = 18'h10;
      do_cycle(r, "t5_vga0");
      r = '{default: '0}; r.dr = 1; r.da = 18'h20; r.edg = 1;
      do_cycle(r, "t5_dec");
      r = '{default: '0}; r.vr = 1; r.va = 18'h11;
      do_cycle(r, "t5_vga1");
      idle(3);

      // Arbitration vector table.
      for (int i = 0; i < 12; i++) begin
         r.vr = tbl[i].vr; r.va = 18'h01000 + 18'(i);
         r.dr = tbl[i].dr; r.dw = tbl[i].dw; r.da = 18'h02000 + 18'(i); r.dd = 16'h5000 + 16'(i);
         r.ur = tbl[i].ur; r.ua = 18'h03000 + 18'(i); r.ud = 16'h6000 + 16'(i);
         r.edg = tbl[i].edg; r.eug = tbl[i].eug;
         do_cycle(r, $sformatf("tbl%0d", i));
      end
      idle(3);

      // UART starvation under continuous VGA traffic.
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         r = '{default: '0};
         r.vr = 1; r.va = 18'(i);
         r.ur = 1; r.ua = 18'h3FF00; r.ud = 16'h7777;
         do_cycle(r, "t6_starve");
         if (i == 253) chk("t6_flag_254", 32'(starve_flag), 32'h0);
         if (i == 254) chk("t6_flag_255", 32'(starve_flag), 32'h2);
      end
      r = '{default: '0};
      r.ur = 1; r.ua = 18'h3FF00; r.ud = 16'h7777; r.eug = 1;
      do_cycle(r, "t6_release");
      idle(3);
      chk("t6_flag_sticky", 32'(starve_flag), 32'h2);

      chk("sb_empty", 32'(sbq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
